muladd_pipe: RTL and testbench

//  Fully pipelined unsigned multiply-accumulate: result = a_in*b_in + c_in, one bit of b_in per stage.

---
 rtl/muladd_pkg.sv | 15 +
 rtl/muladd_stage.sv | 46 ++++
 rtl/muladd_pipe.sv | 60 ++++++
 tb/tb_muladd_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// Shared types and defaults for the pipelined multiply-accumulate block.
package muladd_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ACC_W     = 2 * WIDTH_DEF;

  // One pipeline stage's state at the default operand width.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [ACC_W-1:0]     acc;
  } stage_t;

endpackage

// File: rtl/muladd_stage.sv
// One registered shift-add stage: adds (a << BIT) to the accumulator when b[BIT] is set.
module muladd_stage
  import muladd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BIT   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prev_valid,
  input  logic [WIDTH-1:0]   prev_a,
  input  logic [WIDTH-1:0]   prev_b,
  input  logic [2*WIDTH-1:0] prev_acc,
  output logic               valid,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);

  localparam int AW = 2 * WIDTH;

  logic [AW-1:0] addend;

  always_comb begin
    addend = '0;
    if (prev_b[BIT]) addend = {{WIDTH{1'b0}}, prev_a} << BIT;
  end

  // Data registers only move when a valid op arrives; bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
    end else begin
      valid <= prev_valid;
      if (prev_valid) begin
        a   <= prev_a;
        b   <= prev_b;
        acc <= prev_acc + addend;
      end
    end
  end

endmodule

// File: rtl/muladd_pipe.sv
// Fully pipelined unsigned a*b+c, one multiplier bit per stage, WIDTH-cycle latency.
// Handshake: data_valid_in is sampled every cycle with no backpressure; data_valid_out pulses once per op.
module muladd_pipe
  import muladd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [WIDTH-1:0]   c_in,
  input  logic               data_valid_in,
  output logic [2*WIDTH-1:0] result_out,
  output logic               data_valid_out,
  output logic               error_out,
  output logic               busy_out
);

  localparam int AW = 2 * WIDTH;

  // Index 0 is the input side; index i+1 is the output of stage i.
  logic [WIDTH:0]    vld;
  logic [WIDTH-1:0]  a_s   [WIDTH+1];
  logic [WIDTH-1:0]  b_s   [WIDTH+1];
  logic [AW-1:0]     acc_s [WIDTH+1];
  logic              unused_tail;

  assign vld[0]   = data_valid_in;
  assign a_s[0]   = a_in;
  assign b_s[0]   = b_in;
  assign acc_s[0] = {{WIDTH{1'b0}}, c_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    muladd_stage #(
      .WIDTH (WIDTH),
      .BIT   (i)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst),
      .prev_valid (vld[i]),
      .prev_a     (a_s[i]),
      .prev_b     (b_s[i]),
      .prev_acc   (acc_s[i]),
      .valid      (vld[i+1]),
      .a          (a_s[i+1]),
      .b          (b_s[i+1]),
      .acc        (acc_s[i+1])
    );
  end

  // The last stage's operand copies have no consumer.
  assign unused_tail = ^{a_s[WIDTH], b_s[WIDTH]};

  assign result_out     = acc_s[WIDTH];
  assign data_valid_out = vld[WIDTH];
  assign error_out      = vld[WIDTH] & (|acc_s[WIDTH][AW-1:WIDTH]);
  assign busy_out       = |vld[WIDTH:1];

endmodule

// File: tb/tb_muladd_pipe.sv
// Directed bench for muladd_pipe: latency, corner values, random stream, divider round-trip, mid-flight reset.
module tb_muladd_pipe;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [W-1:0]   c_in;
  logic           data_valid_in;
  logic [2*W-1:0] result_out;
  logic           data_valid_out;
  logic           error_out;
  logic           busy_out;

  int tests = 0;
  int fails = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   hist;

  muladd_pipe #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_in           (a_in),
    .b_in           (b_in),
    .c_in           (c_in),
    .data_valid_in  (data_valid_in),
    .result_out     (result_out),
    .data_valid_out (data_valid_out),
    .error_out      (error_out),
    .busy_out       (busy_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference history of sampled valids: bit j is the op that entered j edges ago.
  always @(posedge clk or negedge rst) begin
    if (!rst) hist <= '0;
    else      hist <= {hist[W-2:0], data_valid_in};
  end

  // scoreboard
  always @(negedge clk) begin
    if (rst) begin
      check("valid_pattern", {63'd0, data_valid_out}, {63'd0, hist[W-1]});
      check("busy_pattern", {63'd0, busy_out}, {63'd0, |hist});
      if (data_valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 64'd1, 64'd0);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          check("result", {32'd0, result_out}, {32'd0, e});
          check("error", {63'd0, error_out}, {63'd0, |e[2*W-1:W]});
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [2*W-1:0] exp);
    data_valid_in = v;
    a_in = a;
    b_in = b;
    c_in = c;
    if (v) exp_q.push_back(exp);
    @(negedge clk);
  endtask

  // Called right after the op's sampling edge; returns the edge count until data_valid_out.
  task automatic wait_out(output int cycles);
    data_valid_in = 1'b0;
    cycles = 1;
    while (!data_valid_out && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    data_valid_in = 1'b0;
    n = 0;
    while ((busy_out || exp_q.size() != 0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, busy_out}, 64'd0);
    check({tag, "_queue"}, exp_q.size(), 64'd0);
  endtask

  initial begin
    int cyc;
    int sent;
    int pulses;
    logic [W-1:0] ra, rb, rc;
    logic [2*W-1:0] rexp;

    rst = 1'b0;
    data_valid_in = 1'b0;
    a_in = '0;
    b_in = '0;
    c_in = '0;
    #1;
    check("rst_valid", {63'd0, data_valid_out}, 64'd0);
    check("rst_busy", {63'd0, busy_out}, 64'd0);
    check("rst_error", {63'd0, error_out}, 64'd0);
    check("rst_result", {32'd0, result_out}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: single op and exact latency
    drive(1'b1, 16'd100, 16'd25, 16'd3, 32'h0000_09C7);
    wait_out(cyc);
    check("t1_latency", cyc, 64'd16);
    check("t1_result", {32'd0, result_out}, 64'h0000_09C7);
    check("t1_error", {63'd0, error_out}, 64'd0);
    drain("t1_drain");

    // 2: result overflows WIDTH bits
    drive(1'b1, 16'd1234, 16'd56, 16'd7, 32'h0001_0DF7);
    wait_out(cyc);
    check("t2_latency", cyc, 64'd16);
    check("t2_result", {32'd0, result_out}, 64'h0001_0DF7);
    check("t2_error", {63'd0, error_out}, 64'd1);
    drain("t2_drain");

    // 3: maximum operands followed back-to-back by zeros
    drive(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000);
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000);
    data_valid_in = 1'b0;
    cyc = 2;
    while (!data_valid_out && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_max_result", {32'd0, result_out}, 64'hFFFF_0000);
    check("t3_max_error", {63'd0, error_out}, 64'd1);
    @(negedge clk);
    check("t3_zero_valid", {63'd0, data_valid_out}, 64'd1);
    check("t3_zero_result", {32'd0, result_out}, 64'd0);
    check("t3_zero_error", {63'd0, error_out}, 64'd0);
    drain("t3_drain");

    // 4: random stream with bubbles, checked by the scoreboard
    sent = 0;
    while (sent < 32) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, '0, '0, '0, '0);
      end else begin
        ra = W'($urandom_range(0, 65535));
        rb = W'($urandom_range(0, 65535));
        rc = W'($urandom_range(0, 65535));
        rexp = 32'(ra) * 32'(rb) + 32'(rc);
        drive(1'b1, ra, rb, rc, rexp);
        sent++;
      end
    end
    drain("t4_drain");

    // 5: divider round-trip 50000 / 7 = 7142 r 6
    drive(1'b1, 16'd7142, 16'd7, 16'd6, 32'd50000);
    wait_out(cyc);
    check("t5_latency", cyc, 64'd16);
    check("t5_result", {32'd0, result_out}, 64'd50000);
    check("t5_error", {63'd0, error_out}, 64'd0);
    drain("t5_drain");

    // 6: asynchronous reset with ops in flight
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(i + 1), 16'd3, 16'd1, '0);
    data_valid_in = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", {63'd0, data_valid_out}, 64'd0);
    check("t6_rst_busy", {63'd0, busy_out}, 64'd0);
    check("t6_rst_result", {32'd0, result_out}, 64'd0);
    check("t6_rst_error", {63'd0, error_out}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (data_valid_out || busy_out) pulses++;
      @(negedge clk);
    end
    check("t6_no_pulses", pulses, 64'd0);
    drive(1'b1, 16'd300, 16'd200, 16'd55, 32'd60055);
    wait_out(cyc);
    check("t6_latency", cyc, 64'd16);
    check("t6_result", {32'd0, result_out}, 64'd60055);
    check("t6_error", {63'd0, error_out}, 64'd0);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
